// File: rtl/disp_scan_ctrl.sv
// ---------------------------------------------------------------------------
// disp_scan_ctrl
//
// Time-multiplexed scan controller for a 4-digit 7-segment display and a
// 4-position character display that share one slot/enable sequence.
//
// The CPU posts a new number/character set with a one-cycle load strobe. That
// data lands in shadow registers and is copied into the active registers only
// at the end of a full 4-slot scan. This keeps a single scan from mixing old
// and new digits.
//
// Optional feature macro: DISP_ZERO_BLANK_EN
//   defined   -> leading zeros on digits 3..1 are blanked (digit 0 always lit)
//   undefined -> every digit shows its hex glyph
//
// Ports
//   clk      : system clock, rising edge
//   rst      : synchronous active-high reset
//   ld       : one-cycle load strobe for ld_num / ld_char
//   ld_num   : four hex digits, [3:0] is digit 0 (rightmost)
//   ld_char  : four 8-bit character codes, [7:0] is position 0
//   num      : active-low segments {g,f,e,d,c,b,a}
//   n_mask   : active-low one-cold digit enables
//   char     : character code for the current position
//   c_mask   : active-low one-cold position enables
//   frame    : one-cycle pulse at the end of each 4-slot scan
//   pend     : shadow holds data not yet committed
// ---------------------------------------------------------------------------
module disp_scan_ctrl #(
    parameter int unsigned DIV = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld,
    input  logic [15:0] ld_num,
    input  logic [31:0] ld_char,
    output logic [6:0]  num,
    output logic [3:0]  n_mask,
    output logic [7:0]  char,
    output logic [3:0]  c_mask,
    output logic        frame,
    output logic        pend
);

    localparam logic [15:0] PCNT_LAST = 16'(DIV - 1);
    localparam logic [6:0]  SEG_BLANK = 7'h7F;

    logic [15:0] pcnt_q;
    logic [1:0]  idx_q;
    logic [15:0] actNum_q;
    logic [31:0] actChar_q;
    logic [15:0] shdNum_q;
    logic [31:0] shdChar_q;
    logic        pend_q;
    logic [6:0]  num_q;
    logic [3:0]  mask_q;
    logic [7:0]  char_q;
    logic        frame_q;

    logic        slotEnd;
    logic        frameEnd;
    logic        commit;
    logic [3:0]  nibble;
    logic        blank;
    logic [6:0]  num_d;
    logic [3:0]  mask_d;
    logic [7:0]  char_d;

    // Hex font, active-low {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hexGlyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'h0:    g = 7'h40;
            4'h1:    g = 7'h79;
            4'h2:    g = 7'h24;
            4'h3:    g = 7'h30;
            4'h4:    g = 7'h19;
            4'h5:    g = 7'h12;
            4'h6:    g = 7'h02;
            4'h7:    g = 7'h78;
            4'h8:    g = 7'h00;
            4'h9:    g = 7'h10;
            4'hA:    g = 7'h08;
            4'hB:    g = 7'h03;
            4'hC:    g = 7'h46;
            4'hD:    g = 7'h21;
            4'hE:    g = 7'h06;
            default: g = 7'h0E;
        endcase
        return g;
    endfunction

    // Scan-position decode. The commit happens only on the last cycle of
    // slot 3, so the new data always starts displaying at digit 0.
    always_comb begin
        slotEnd  = (pcnt_q == PCNT_LAST);
        frameEnd = slotEnd && (idx_q == 2'd3);
        commit   = frameEnd && pend_q;
    end

    // Leading-zero test: digit k is blank when it and every higher nibble
    // are zero. Digit 0 is never blanked so "0" still shows.
    always_comb begin
        blank = 1'b0;
`ifdef DISP_ZERO_BLANK_EN
        case (idx_q)
            2'd3:    blank = (actNum_q[15:12] == 4'h0);
            2'd2:    blank = (actNum_q[15:8]  == 8'h00);
            2'd1:    blank = (actNum_q[15:4]  == 12'h000);
            default: blank = 1'b0;
        endcase
`endif
    end

    // Output values for the slot currently selected; registered below so
    // the segments and enables change together on one edge.
    always_comb begin
        nibble = actNum_q[{idx_q, 2'b00} +: 4];
        num_d  = blank ? SEG_BLANK : hexGlyph(nibble);
        mask_d = ~(4'b0001 << idx_q);
        char_d = actChar_q[{idx_q, 3'b000} +: 8];
    end

    // All state. A load coinciding with a commit still commits the old
    // shadow (the right-hand side reads the pre-edge shadow), while the new
    // load refills the shadow and keeps pend set for the next frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_q    <= '0;
            idx_q     <= '0;
            actNum_q  <= '0;
            actChar_q <= '0;
            shdNum_q  <= '0;
            shdChar_q <= '0;
            pend_q    <= 1'b0;
            num_q     <= SEG_BLANK;
            mask_q    <= 4'hF;
            char_q    <= 8'h00;
            frame_q   <= 1'b0;
        end else begin
            pcnt_q  <= slotEnd ? 16'd0 : pcnt_q + 16'd1;
            if (slotEnd) begin
                idx_q <= idx_q + 2'd1;
            end
            if (commit) begin
                actNum_q  <= shdNum_q;
                actChar_q <= shdChar_q;
            end
            if (ld) begin
                shdNum_q  <= ld_num;
                shdChar_q <= ld_char;
            end
            pend_q  <= ld | (pend_q & ~commit);
            num_q   <= num_d;
            mask_q  <= mask_d;
            char_q  <= char_d;
            frame_q <= frameEnd;
        end
    end

    assign num    = num_q;
    assign n_mask = mask_q;
    assign char   = char_q;
    assign c_mask = mask_q;
    assign frame  = frame_q;
    assign pend   = pend_q;

endmodule
